// File: rtl/stage_ex_pkg.sv
// Encodings shared by the execute stage and its pipeline neighbours:
// ALU operation codes, write-back info and the mul/div sequencer states.
package stage_ex_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
   localparam logic [3:0] ALU_MUL  = 4'd12;
   localparam logic [3:0] ALU_DIV  = 4'd13;
   localparam logic [3:0] ALU_DIVU = 4'd14;
   localparam logic [3:0] ALU_REM  = 4'd15;

   typedef enum logic [1:0] {
      WBI_NONE = 2'b00,
      WBI_ALU  = 2'b01,
      WBI_MEM  = 2'b10,
      WBI_LINK = 2'b11
   } wbi_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   // The multi-cycle ops occupy the top quarter of the opcode space.
   function automatic logic is_md_op(input logic [3:0] op);
      return op[3:2] == 2'b11;
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, with the result sign applied on the final iteration.
module mul_div_unit
   import stage_ex_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MD_STEPS = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CNT_W = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_STEPS - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       op_q;
   logic             neg_q, div0_q;
   logic [WIDTH-1:0] a_raw_q, x_q, y_q, acc_q;
   logic [WIDTH-1:0] x_n, y_n, acc_n, mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_diff;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                   input logic neg);
      return neg ? -m : m;
   endfunction

   // DIVU treats both operands as unsigned; every other op works on magnitudes.
   always_comb begin
      a_neg = (op_i != ALU_DIVU) && a_i[WIDTH-1];
      b_neg = (op_i != ALU_DIVU) && b_i[WIDTH-1];
      a_mag = apply_sign(a_i, a_neg);
      b_mag = apply_sign(b_i, b_neg);
   end

   // One iteration: MUL uses x as multiplier, y as shifting multiplicand;
   // divide uses x as dividend/quotient shifter, y as divisor, acc as remainder.
   always_comb begin
      rem_sh   = {acc_q, x_q[WIDTH-1]};
      rem_diff = rem_sh[WIDTH-1:0] - y_q;
      x_n      = x_q;
      y_n      = y_q;
      acc_n    = acc_q;
      if (op_q == ALU_MUL) begin
         acc_n = x_q[0] ? (acc_q + y_q) : acc_q;
         x_n   = x_q >> 1;
         y_n   = y_q << 1;
      end else if (rem_sh >= {1'b0, y_q}) begin
         acc_n = rem_diff;
         x_n   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_n = rem_sh[WIDTH-1:0];
         x_n   = {x_q[WIDTH-2:0], 1'b0};
      end
      mag = (op_q == ALU_MUL || op_q == ALU_REM) ? acc_n : x_n;
      if (div0_q) begin
         result_o = (op_q == ALU_REM) ? a_raw_q : '1;
      end else begin
         result_o = apply_sign(mag, neg_q);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start_i) begin
               state_d = MD_BUSY;
               cnt_d   = '0;
            end
         end
         MD_BUSY: begin
            busy_o = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               done_o  = 1'b1;
               state_d = MD_DONE;
            end
         end
         MD_DONE: begin
            if (start_i) begin
               state_d = MD_BUSY;
               cnt_d   = '0;
            end else begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand/iteration datapath: loaded on start, advanced while busy.
   always_ff @(posedge clk_i) begin
      if (start_i && !busy_o) begin
         op_q    <= op_i;
         a_raw_q <= a_i;
         neg_q   <= (op_i == ALU_REM) ? a_neg : (a_neg ^ b_neg);
         div0_q  <= (op_i != ALU_MUL) && (b_i == '0);
         acc_q   <= '0;
         if (op_i == ALU_MUL) begin
            x_q <= b_mag;
            y_q <= a_mag;
         end else begin
            x_q <= a_mag;
            y_q <= b_mag;
         end
      end else if (busy_o) begin
         x_q   <= x_n;
         y_q   <= y_n;
         acc_q <= acc_n;
      end
   end

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: single-cycle ALU, branch resolution, destination select
// and the EX/MEM register; multi-cycle MUL/DIV/REM stall the front end.
module stage_ex
   import stage_ex_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MD_STEPS = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             inValid,
   input  logic [WIDTH-1:0] pcPlus4,
   input  logic [3:0]       aluOp,
   input  logic             isJump,
   input  logic             isNotConditional,
   input  logic             isEq,
   input  logic             memWrite,
   input  logic             memRead,
   input  logic [1:0]       wbi,
   input  logic             aluSrc,
   input  logic             regDst,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   input  logic [WIDTH-1:0] extendedInstr,
   input  logic [4:0]       regAddr1,
   input  logic [4:0]       regAddr2,
   output logic             outValid,
   output logic [WIDTH-1:0] aluResult,
   output logic [WIDTH-1:0] storeData,
   output logic [4:0]       writeAddr,
   output logic             memWriteOut,
   output logic             memReadOut,
   output logic [1:0]       wbiOut,
   output logic             branchTaken,
   output logic [WIDTH-1:0] branchTarget,
   output logic             stall
);

   logic             md_start, md_busy, md_done;
   logic [WIDTH-1:0] md_result;
   logic             accept, is_md, br_taken;
   logic [WIDTH-1:0] op_b, alu_res, br_target;
   logic [4:0]       dest;
   logic             unused_regaddr1;

   logic             valid_q, valid_d, memw_q, memw_d, memr_q, memr_d;
   logic             btaken_q, btaken_d;
   logic [1:0]       wbi_q, wbi_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [WIDTH-1:0] result_q, result_d, store_q, store_d, btarget_q, btarget_d;

   // Bundle of the instruction in the mul/div unit, captured when it starts.
   logic [4:0]       md_waddr_q;
   logic [WIDTH-1:0] md_store_q;
   logic [1:0]       md_wbi_q;
   logic             md_memw_q, md_memr_q;

   function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] rt,
                                                    input logic [4:0]       shamt);
      logic signed [WIDTH-1:0] a_s, b_s, rt_s;
      a_s  = a;
      b_s  = b;
      rt_s = rt;
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return WIDTH'(a_s < b_s);
         ALU_SLTU: return WIDTH'(a < b);
         ALU_SLL:  return rt << shamt;
         ALU_SRL:  return rt >> shamt;
         ALU_SRA:  return rt_s >>> shamt;
         ALU_LUI:  return WIDTH'(b[15:0]) << 16;
         default:  return '0;
      endcase
   endfunction

   assign unused_regaddr1 = ^regAddr1;

   assign is_md     = is_md_op(aluOp);
   assign accept    = inValid && !md_busy;
   assign md_start  = accept && is_md;
   assign op_b      = aluSrc ? extendedInstr : reg2;
   assign alu_res   = alu_compute(aluOp, reg1, op_b, reg2, extendedInstr[10:6]);
   assign dest      = regDst ? extendedInstr[15:11] : regAddr2;
   assign br_taken  = isJump && (isNotConditional || ((reg1 == reg2) == isEq));
   assign br_target = pcPlus4 + (extendedInstr << 2);

   mul_div_unit #(
      .WIDTH    (WIDTH),
      .MD_STEPS (MD_STEPS)
   ) u_mul_div (
      .clk_i    (clock),
      .rst_n_i  (reset_n),
      .start_i  (md_start),
      .op_i     (aluOp),
      .a_i      (reg1),
      .b_i      (op_b),
      .busy_o   (md_busy),
      .done_o   (md_done),
      .result_o (md_result)
   );

   always_ff @(posedge clock) begin
      if (md_start) begin
         md_waddr_q <= dest;
         md_store_q <= reg2;
         md_wbi_q   <= wbi;
         md_memw_q  <= memWrite;
         md_memr_q  <= memRead;
      end
   end

   // EX/MEM next state: control strobes default low, data holds.
   always_comb begin
      valid_d   = 1'b0;
      memw_d    = 1'b0;
      memr_d    = 1'b0;
      wbi_d     = WBI_NONE;
      btaken_d  = 1'b0;
      result_d  = result_q;
      store_d   = store_q;
      waddr_d   = waddr_q;
      btarget_d = btarget_q;
      if (md_done) begin
         valid_d  = 1'b1;
         result_d = md_result;
         store_d  = md_store_q;
         waddr_d  = md_waddr_q;
         wbi_d    = md_wbi_q;
         memw_d   = md_memw_q;
         memr_d   = md_memr_q;
      end else if (accept && !is_md) begin
         valid_d   = 1'b1;
         result_d  = alu_res;
         store_d   = reg2;
         waddr_d   = dest;
         btarget_d = br_target;
         if (isJump) begin
            btaken_d = br_taken;
         end else begin
            wbi_d  = wbi;
            memw_d = memWrite;
            memr_d = memRead;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         memw_q    <= 1'b0;
         memr_q    <= 1'b0;
         wbi_q     <= WBI_NONE;
         btaken_q  <= 1'b0;
         result_q  <= '0;
         store_q   <= '0;
         waddr_q   <= '0;
         btarget_q <= '0;
      end else begin
         valid_q   <= valid_d;
         memw_q    <= memw_d;
         memr_q    <= memr_d;
         wbi_q     <= wbi_d;
         btaken_q  <= btaken_d;
         result_q  <= result_d;
         store_q   <= store_d;
         waddr_q   <= waddr_d;
         btarget_q <= btarget_d;
      end
   end

   assign outValid     = valid_q;
   assign aluResult    = result_q;
   assign storeData    = store_q;
   assign writeAddr    = waddr_q;
   assign memWriteOut  = memw_q;
   assign memReadOut   = memr_q;
   assign wbiOut       = wbi_q;
   assign branchTaken  = btaken_q;
   assign branchTarget = btarget_q;
   assign stall        = md_busy;

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed plus randomized instructions
// checked against an arithmetic reference model of the execute stage.
module tb_stage_ex;

   logic        clock, reset_n, inValid, isJump, isNotConditional, isEq;
   logic        memWrite, memRead, aluSrc, regDst;
   logic [31:0] pcPlus4, reg1, reg2, extendedInstr;
   logic [3:0]  aluOp;
   logic [1:0]  wbi;
   logic [4:0]  regAddr1, regAddr2;
   logic        outValid, memWriteOut, memReadOut, branchTaken, stall;
   logic [31:0] aluResult, storeData, branchTarget;
   logic [4:0]  writeAddr;
   logic [1:0]  wbiOut;

   int n_cmp  = 0;
   int n_fail = 0;

   stage_ex #(.WIDTH(32), .MD_STEPS(32)) dut (
      .clock(clock), .reset_n(reset_n), .inValid(inValid), .pcPlus4(pcPlus4),
      .aluOp(aluOp), .isJump(isJump), .isNotConditional(isNotConditional),
      .isEq(isEq), .memWrite(memWrite), .memRead(memRead), .wbi(wbi),
      .aluSrc(aluSrc), .regDst(regDst), .reg1(reg1), .reg2(reg2),
      .extendedInstr(extendedInstr), .regAddr1(regAddr1), .regAddr2(regAddr2),
      .outValid(outValid), .aluResult(aluResult), .storeData(storeData),
      .writeAddr(writeAddr), .memWriteOut(memWriteOut), .memReadOut(memReadOut),
      .wbiOut(wbiOut), .branchTaken(branchTaken), .branchTarget(branchTarget),
      .stall(stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rt, input logic [31:0] ext,
                                             input logic src);
      logic [31:0] b;
      int unsigned sh;
      int sa, sb, srt;
      b   = src ? ext : rt;
      sh  = ext[10:6];
      sa  = a;
      sb  = b;
      srt = rt;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return rt << sh;
         4'd9:  return rt >> sh;
         4'd10: return 32'(srt >>> sh);
         4'd11: return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_md(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd12: r = sa * sb;
         4'd13: r = (b == 32'd0) ? -64'sd1 : sa / sb;
         4'd14: r = (b == 32'd0) ? -64'sd1 : longint'(a / b);
         default: r = (b == 32'd0) ? sa : sa % sb;
      endcase
      return r[31:0];
   endfunction

   function automatic logic [75:0] bundle(input logic v, input logic [31:0] r, input logic [31:0] s,
                                          input logic [4:0] w, input logic mw, input logic mr,
                                          input logic [1:0] wb, input logic bt, input logic st);
      return {v, r, s, w, mw, mr, wb, bt, st};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_idle();
      inValid = 0; isJump = 0; isNotConditional = 0; isEq = 0;
      memWrite = 0; memRead = 0; wbi = 0; aluSrc = 0; regDst = 0;
      pcPlus4 = 0; aluOp = 0; reg1 = 0; reg2 = 0; extendedInstr = 0;
      regAddr1 = 0; regAddr2 = 0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] ext, input logic src, input logic rdst,
                        input logic [1:0] wb, input logic mw, input logic mr, input logic [4:0] ra2);
      inValid = 1; isJump = 0; isNotConditional = 0; isEq = 0;
      aluOp = op; reg1 = r1; reg2 = r2; extendedInstr = ext; aluSrc = src; regDst = rdst;
      wbi = wb; memWrite = mw; memRead = mr; regAddr2 = ra2;
      regAddr1 = 5'($urandom); pcPlus4 = $urandom;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle();
      reset_n = 0;
      drive(4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 5'd4);
      tick();
      tick();
      n_cmp++;
      if (bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut, wbiOut,
                 branchTaken, stall) !== 76'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b res=%h wbi=%h stall=%b want all zero",
                  outValid, aluResult, wbiOut, stall);
      end
      n_cmp++;
      if (branchTarget !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_target: got %h want 00000000", branchTarget);
      end
      set_idle();
      reset_n = 1;
      tick();
   endtask

   task automatic test_add_directed();
      drive(4'd0, 32'h5, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 5'd3);
      tick();
      n_cmp++;
      if (bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut, wbiOut,
                 branchTaken, stall) !== bundle(1, 32'h4, 32'h1234, 5'd3, 0, 0, 2'd1, 0, 0)) begin
         n_fail++;
         $display("FAIL add_imm: got valid=%b res=%h wa=%0d stall=%b want valid=1 res=00000004 wa=3 stall=0",
                  outValid, aluResult, writeAddr, stall);
      end
      set_idle();
      tick();
      n_cmp++;
      if ({outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall} !== 7'd0) begin
         n_fail++;
         $display("FAIL add_idle_after: got flags %b want 0000000",
                  {outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall});
      end
   endtask

   task automatic test_alu_random(input int n);
      logic [3:0]  op;
      logic [31:0] r1, r2, ext, want;
      logic        src, rdst, mw, mr;
      logic [1:0]  wb;
      logic [4:0]  ra2, wa;
      logic [75:0] got, exp_b;
      for (int i = 0; i < n; i++) begin
         op   = 4'($urandom_range(0, 11));
         r1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         r2   = $urandom;
         ext  = $urandom;
         ext  = {{16{ext[15]}}, ext[15:0]};
         src  = 1'($urandom_range(0, 1));
         rdst = 1'($urandom_range(0, 1));
         mw   = 1'($urandom_range(0, 1));
         mr   = 1'($urandom_range(0, 1));
         wb   = 2'($urandom_range(0, 3));
         ra2  = 5'($urandom);
         want = model_alu(op, r1, r2, ext, src);
         wa   = rdst ? ext[15:11] : ra2;
         drive(op, r1, r2, ext, src, rdst, wb, mw, mr, ra2);
         tick();
         got   = bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut,
                        wbiOut, branchTaken, stall);
         exp_b = bundle(1, want, r2, wa, mw, mr, wb, 0, 0);
         n_cmp++;
         if (got !== exp_b) begin
            n_fail++;
            $display("FAIL alu_op%0d: got %h want %h (a=%h b=%h ext=%h src=%b)",
                     op, got, exp_b, r1, r2, ext, src);
         end
         if ($urandom_range(0, 3) == 0) begin
            set_idle();
            tick();
            n_cmp++;
            if ({outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall} !== 7'd0) begin
               n_fail++;
               $display("FAIL alu_idle: got flags %b want 0000000",
                        {outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall});
            end
         end
      end
   endtask

   task automatic run_branch(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ext,
                             input logic [31:0] pc, input logic nc, input logic eq,
                             input string name);
      logic        taken;
      logic [31:0] tgt;
      logic [75:0] got, exp_b;
      taken = nc || ((r1 == r2) == eq);
      tgt   = pc + ext * 4;
      drive(4'd1, r1, r2, ext, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 5'd7);
      isJump = 1; isNotConditional = nc; isEq = eq; pcPlus4 = pc;
      tick();
      got   = bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut,
                     wbiOut, branchTaken, stall);
      exp_b = bundle(1, r1 - r2, r2, 5'd7, 0, 0, 2'd0, taken, 0);
      n_cmp++;
      if (got !== exp_b) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, exp_b);
      end
      n_cmp++;
      if (branchTarget !== tgt) begin
         n_fail++;
         $display("FAIL %s_target: got %h want %h", name, branchTarget, tgt);
      end
      set_idle();
      tick();
      n_cmp++;
      if ({outValid, branchTaken} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_pulse: got valid=%b taken=%b want 0 0", name, outValid, branchTaken);
      end
   endtask

   task automatic test_branch();
      logic [31:0] r1, r2, ext;
      run_branch(32'd7, 32'd7, 32'h3, 32'h100, 1'b0, 1'b1, "beq_taken");
      run_branch(32'd7, 32'd8, 32'h3, 32'h100, 1'b0, 1'b1, "beq_not_taken");
      for (int i = 0; i < 16; i++) begin
         r1  = $urandom;
         r2  = ($urandom_range(0, 1) == 1) ? r1 : $urandom;
         ext = $urandom;
         ext = {{16{ext[15]}}, ext[15:0]};
         run_branch(r1, r2, ext, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), "branch_rand");
      end
   endtask

   task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input logic follow_add);
      logic [31:0] ext, want, r1, r2;
      logic [4:0]  ra2, wa;
      logic [1:0]  wb;
      logic        mw, mr, rdst;
      logic [75:0] got, exp_b;
      int          cyc;
      ext  = $urandom;
      ra2  = 5'($urandom);
      wb   = 2'($urandom_range(0, 3));
      mw   = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      rdst = 1'($urandom_range(0, 1));
      wa   = rdst ? ext[15:11] : ra2;
      want = model_md(op, a, b);
      drive(op, a, b, ext, 1'b0, rdst, wb, mw, mr, ra2);
      tick();
      n_cmp++;
      if ({outValid, stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s_start: got valid=%b stall=%b want 0 1", name, outValid, stall);
      end
      cyc = 1;
      while (stall === 1'b1 && cyc < 200) begin
         tick();
         if (stall === 1'b1) cyc++;
      end
      n_cmp++;
      if (cyc != 32) begin
         n_fail++;
         $display("FAIL %s_stall_len: got %0d cycles want 32", name, cyc);
      end
      got   = bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut,
                     wbiOut, branchTaken, stall);
      exp_b = bundle(1, want, b, wa, mw, mr, wb, 0, 0);
      n_cmp++;
      if (got !== exp_b) begin
         n_fail++;
         $display("FAIL %s_result: got res=%h bundle %h want res=%h bundle %h (a=%h b=%h)",
                  name, aluResult, got, want, exp_b, a, b);
      end
      if (follow_add) begin
         r1 = $urandom;
         r2 = $urandom;
         drive(4'd0, r1, r2, 32'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 5'd12);
         tick();
         n_cmp++;
         if ({outValid, aluResult, writeAddr, stall} !== {1'b1, r1 + r2, 5'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_next_add: got valid=%b res=%h stall=%b want 1 %h 0",
                     name, outValid, aluResult, stall, r1 + r2);
         end
      end
      set_idle();
      tick();
      n_cmp++;
      if ({outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall} !== 7'd0) begin
         n_fail++;
         $display("FAIL %s_idle: got flags %b want 0000000",
                  name, {outValid, memWriteOut, memReadOut, wbiOut, branchTaken, stall});
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  op;
      logic [31:0] a, b;
      run_md(4'd12, 32'hFFFF_FFFD, 32'd7, "mul_neg", 1'b1);
      run_md(4'd13, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
      run_md(4'd15, 32'hFFFF_FFF9, 32'd2, "rem_neg", 1'b0);
      run_md(4'd14, 32'd5, 32'd0, "divu_zero", 1'b0);
      run_md(4'd13, 32'hFFFF_FFF9, 32'd0, "div_zero", 1'b0);
      run_md(4'd15, 32'hFFFF_FFF9, 32'd0, "rem_zero", 1'b0);
      run_md(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
      run_md(4'd15, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b1);
      for (int i = 0; i < 12; i++) begin
         op = 4'($urandom_range(12, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if ($urandom_range(0, 1) == 1) b = -b;
         run_md(op, a, b, "md_rand", 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_midbusy();
      drive(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 5'd5);
      tick();
      for (int i = 0; i < 10; i++) tick();
      n_cmp++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL midbusy_pre: got stall=%b want 1", stall);
      end
      reset_n = 0;
      tick();
      n_cmp++;
      if (bundle(outValid, aluResult, storeData, writeAddr, memWriteOut, memReadOut, wbiOut,
                 branchTaken, stall) !== 76'd0 || branchTarget !== 32'd0) begin
         n_fail++;
         $display("FAIL midbusy_reset: got valid=%b res=%h stall=%b tgt=%h want all zero",
                  outValid, aluResult, stall, branchTarget);
      end
      reset_n = 1;
      drive(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 5'd6);
      tick();
      n_cmp++;
      if ({outValid, aluResult, writeAddr, stall} !== {1'b1, 32'd42, 5'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL midbusy_add: got valid=%b res=%h wa=%0d stall=%b want 1 0000002a 6 0",
                  outValid, aluResult, writeAddr, stall);
      end
      set_idle();
      tick();
      n_cmp++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL midbusy_no_resume: got stall=%b want 0", stall);
      end
   endtask

   task automatic test_sra_regdst();
      drive(4'd10, 32'd0, 32'h8000_0000, 32'h0000_4900, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd2);
      tick();
      n_cmp++;
      if ({outValid, aluResult, writeAddr} !== {1'b1, 32'hF800_0000, 5'd9}) begin
         n_fail++;
         $display("FAIL sra_regdst: got valid=%b res=%h wa=%0d want 1 f8000000 9",
                  outValid, aluResult, writeAddr);
      end
      set_idle();
      tick();
   endtask

   initial begin
      set_idle();
      reset_n = 0;
      test_reset();
      test_add_directed();
      test_sra_regdst();
      test_alu_random(60);
      test_branch();
      test_muldiv();
      test_reset_midbusy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
